// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1 by default) with a two-flop input synchroniser,
// mid-bit sampling, stop-bit checking and a valid/ready output holding register.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_meta;
    logic                 rx_s;

    // Synchroniser flops come out of reset high so an idle line is not seen as a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is a handful of flops, not a memory, so it is reset with the rest.
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            // NOTE: non-blocking assignments resolve last-wins, so a load in STOP below overrides this clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end

                    START: begin
                        if (cnt == CNT_MID) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == IDX_LAST)
                                state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (rx_valid && !rx_ready) begin
                                overrun_err <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames, queues expected bytes and
// compares them as the receiver hands them over; also tallies error pulses.
module tb_uart_rx;

    localparam int TICK_DIV = 20;             // clk per tick; the receiver only counts ticks
    localparam int BIT_CLK  = TICK_DIV * 16;  // clk per bit period
    localparam int GLITCH_CLK = TICK_DIV * 4; // well short of the 8-tick mid-start check

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    int n_acc = 0;
    int n_fe  = 0;
    int n_ov  = 0;
    logic saw_busy = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tcnt == TICK_DIV - 1) begin
                tcnt = 0;
                tick = 1'b1;
            end else begin
                tcnt++;
                tick = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on each accept and tallies error pulses.
    initial begin
        logic       hold_chk = 1'b0;
        logic [7:0] held     = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (hold_chk && rx_valid)
                    check("hold", {24'h0, rx_data}, {24'h0, held});
                if (rx_valid && rx_ready) begin
                    n_acc++;
                    if (sb.size() == 0) begin
                        check("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] exp_b;
                        exp_b = sb.pop_front();
                        check("data", {24'h0, rx_data}, {24'h0, exp_b});
                    end
                end
                if (frame_err)   n_fe++;
                if (overrun_err) n_ov++;
                if (busy)        saw_busy = 1'b1;
                hold_chk = rx_valid && !rx_ready;
                held     = rx_data;
            end else begin
                hold_chk = 1'b0;
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    initial begin
        int fe0, ov0, acc0;
        logic [7:0] c3;

        wait_clk(4);
        @(negedge clk);
        check("rst_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_data", {24'h0, rx_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        check("rst_oerr", {31'h0, overrun_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clk(BIT_CLK);

        // Two clean frames, consumer always ready
        rx_ready = 1'b1;
        fe0 = n_fe; ov0 = n_ov; acc0 = n_acc;
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        sb.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        wait_clk(BIT_CLK);
        check("two_frames_acc", n_acc - acc0, 2);
        check("two_frames_sb", sb.size(), 0);
        check("two_frames_ferr", n_fe - fe0, 0);
        check("two_frames_oerr", n_ov - ov0, 0);

        // Overrun: second byte arrives while the first is still pending
        rx_ready = 1'b0;
        ov0 = n_ov;
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_clk(BIT_CLK);
        check("ovr_pulses", n_ov - ov0, 1);
        check("ovr_valid", {31'h0, rx_valid}, 32'h1);
        check("ovr_data", {24'h0, rx_data}, 32'h12);
        rx_ready = 1'b1;
        wait_clk(3);
        check("ovr_drain_valid", {31'h0, rx_valid}, 32'h0);
        check("ovr_drain_sb", sb.size(), 0);

        // Framing error, then a good byte
        fe0 = n_fe; acc0 = n_acc;
        send_frame(8'hFF, 1'b0);
        wait_clk(BIT_CLK);
        check("ferr_pulses", n_fe - fe0, 1);
        check("ferr_no_byte", n_acc - acc0, 0);
        check("ferr_valid", {31'h0, rx_valid}, 32'h0);
        check("ferr_busy", {31'h0, busy}, 32'h0);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clk(BIT_CLK);
        check("after_ferr_sb", sb.size(), 0);

        // Short low glitch on an idle line
        fe0 = n_fe; ov0 = n_ov; acc0 = n_acc;
        saw_busy = 1'b0;
        rx = 1'b0;
        wait_clk(GLITCH_CLK);
        rx = 1'b1;
        wait_clk(BIT_CLK);
        check("glitch_busy_seen", {31'h0, saw_busy}, 32'h1);
        check("glitch_busy_idle", {31'h0, busy}, 32'h0);
        check("glitch_no_byte", n_acc - acc0, 0);
        check("glitch_no_ferr", n_fe - fe0, 0);
        check("glitch_no_oerr", n_ov - ov0, 0);

        // Reset in the middle of data bit 4
        acc0 = n_acc;
        c3 = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(c3[i]);
        rx = c3[4];
        wait_clk(BIT_CLK / 2);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'h0, rx_valid}, 32'h0);
        check("midrst_data", {24'h0, rx_data}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_ferr", {31'h0, frame_err}, 32'h0);
        check("midrst_oerr", {31'h0, overrun_err}, 32'h0);
        wait_clk(2 * BIT_CLK);
        check("midrst_no_byte", n_acc - acc0, 0);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_clk(BIT_CLK);
        check("after_rst_sb", sb.size(), 0);

        // Back-to-back frames with no idle gap
        fe0 = n_fe; ov0 = n_ov; acc0 = n_acc;
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_clk(BIT_CLK);
        check("b2b_acc", n_acc - acc0, 3);
        check("b2b_sb", sb.size(), 0);
        check("b2b_ferr", n_fe - fe0, 0);
        check("b2b_oerr", n_ov - ov0, 0);

        check("total_bytes", n_acc, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
